// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU multicycle memory bus.
// Requests use a req/ack handshake. Each request is served either from an
// internal single-port word RAM at address 0 upward, or from a small I/O
// page at IO_BASE:
//   +0  io_in    read-only (writes are ignored and do not set bus_error)
//   +1  io_out   read/write output register
//   +2  timer    read/write free-running counter
// Any other address is unmapped. Unmapped reads return 0, unmapped writes
// are dropped, and both still get an ack and set the sticky bus_error.
//
// Ports:
//   clk                rising-edge clock
//   reset              synchronous active-low reset
//   mem_req            request valid, held by the initiator until mem_ack
//   mem_we             1 = store, 0 = load/fetch
//   mem_address        word address
//   data_to_mem_store  store data
//   data_from_mem      read data, held until the next read completes
//   mem_ack            one-cycle completion pulse
//   io_in              external input port
//   io_out             external output port register
//   bus_error          sticky unmapped-access flag
//
// state | meaning
// IDLE  | waiting; writes commit here, reads latch the address
// READ  | registered RAM data available; load data_from_mem
// ACK   | mem_ack high for this one cycle
module mem_responder #(
  parameter int               WIDTH         = 16,
  parameter int               RAM_ADDR_BITS = 10,
  parameter logic [WIDTH-1:0] IO_BASE       = 16'hFF00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_req,
  input  logic             mem_we,
  input  logic [WIDTH-1:0] mem_address,
  input  logic [WIDTH-1:0] data_to_mem_store,
  output logic [WIDTH-1:0] data_from_mem,
  output logic             mem_ack,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  output logic             bus_error
);

  typedef enum logic [1:0] {IDLE, READ, ACK} state_t;
  typedef enum logic [2:0] {D_RAM, D_IN, D_OUT, D_TMR, D_NONE} dec_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] io_out_q, io_out_d;
  logic [WIDTH-1:0] timer_q, timer_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] addr_q, addr_d;

  logic [WIDTH-1:0] ram_mem [0:(1<<RAM_ADDR_BITS)-1];
  logic [WIDTH-1:0] ram_rdata_q;
  logic             ram_we;
  logic             ram_re;
  dec_t             req_dec;
  dec_t             rd_dec;

  function automatic dec_t decode(input logic [WIDTH-1:0] a);
    if (a[WIDTH-1:RAM_ADDR_BITS] == '0)   return D_RAM;
    else if (a == IO_BASE)                return D_IN;
    else if (a == IO_BASE + WIDTH'(1))    return D_OUT;
    else if (a == IO_BASE + WIDTH'(2))    return D_TMR;
    else                                  return D_NONE;
  endfunction

  assign req_dec = decode(mem_address);
  assign rd_dec  = decode(addr_q);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    io_out_d = io_out_q;
    timer_d  = timer_q + WIDTH'(1);
    err_d    = err_q;
    addr_d   = addr_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          if (req_dec == D_NONE) err_d = 1'b1;
          if (mem_we) begin
            ram_we = (req_dec == D_RAM);
            if (req_dec == D_OUT) io_out_d = data_to_mem_store;
            // a timer write overrides this cycle's increment
            if (req_dec == D_TMR) timer_d = data_to_mem_store;
            state_d = ACK;
          end else begin
            addr_d  = mem_address;
            ram_re  = (req_dec == D_RAM);
            state_d = READ;
          end
        end
      end
      READ: begin
        case (rd_dec)
          D_RAM:   data_d = ram_rdata_q;
          D_IN:    data_d = io_in;
          D_OUT:   data_d = io_out_q;
          D_TMR:   data_d = timer_q;
          default: data_d = '0;
        endcase
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM has no reset; the write is gated so reset beats a same-cycle store.
  always_ff @(posedge clk) begin
    if (reset && ram_we) ram_mem[mem_address[RAM_ADDR_BITS-1:0]] <= data_to_mem_store;
    if (ram_re)          ram_rdata_q <= ram_mem[mem_address[RAM_ADDR_BITS-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      io_out_q <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      io_out_q <= io_out_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
    end
  end

  assign mem_ack       = (state_q == ACK);
  assign data_from_mem = data_q;
  assign io_out        = io_out_q;
  assign bus_error     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_address;
  logic [15:0] data_to_mem_store;
  logic [15:0] data_from_mem;
  logic        mem_ack;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic        bus_error;

  mem_responder dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_address(mem_address), .data_to_mem_store(data_to_mem_store),
    .data_from_mem(data_from_mem), .mem_ack(mem_ack), .io_in(io_in),
    .io_out(io_out), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit en       = 0;
  bit rnd_io   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: memory image, I/O registers, timer as
  // (load value, load edge), and the edge numbers at which the current
  // request completes and the responder can accept the next one.
  logic [15:0] m_ram [0:1023];
  logic [15:0] m_io_out = 0;
  logic [15:0] m_data   = 0;
  logic        m_err    = 0;
  logic [15:0] t_base   = 0;
  int          t_cyc    = 0;
  int          cyc      = 0;
  int          ack_at   = -1;
  int          next_free = 0;
  bit          rd_pend  = 0;
  int          rd_at    = 0;
  logic [15:0] rd_addr  = 0;

  function automatic logic [15:0] timer_after(input int edge_n);
    return t_base + 16'(edge_n - t_cyc);
  endfunction

  function automatic bit mapped(input logic [15:0] a);
    return (a < 16'd1024) || (a == 16'hFF00) || (a == 16'hFF01) || (a == 16'hFF02);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_io_out = 0; m_data = 0; m_err = 0;
      t_base = 0; t_cyc = cyc;
      ack_at = -1; rd_pend = 0; next_free = cyc + 1;
    end else begin
      if (rd_pend && rd_at == cyc) begin
        rd_pend = 0;
        if (rd_addr < 16'd1024)      m_data = m_ram[rd_addr[9:0]];
        else if (rd_addr == 16'hFF00) m_data = io_in;
        else if (rd_addr == 16'hFF01) m_data = m_io_out;
        else if (rd_addr == 16'hFF02) m_data = timer_after(cyc - 1);
        else                          m_data = 0;
      end
      if (cyc >= next_free && mem_req) begin
        if (!mapped(mem_address)) m_err = 1;
        if (mem_we) begin
          if (mem_address < 16'd1024) m_ram[mem_address[9:0]] = data_to_mem_store;
          else if (mem_address == 16'hFF01) m_io_out = data_to_mem_store;
          else if (mem_address == 16'hFF02) begin t_base = data_to_mem_store; t_cyc = cyc; end
          ack_at = cyc; next_free = cyc + 2;
        end else begin
          rd_pend = 1; rd_addr = mem_address; rd_at = cyc + 1;
          ack_at = cyc + 1; next_free = cyc + 3;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("cyc_mem_ack", {15'b0, mem_ack}, {15'b0, (ack_at == cyc)});
      chk("cyc_data_from_mem", data_from_mem, m_data);
      chk("cyc_io_out", io_out, m_io_out);
      chk("cyc_bus_error", {15'b0, bus_error}, {15'b0, m_err});
    end
  end

  // Called at a negedge; returns one negedge after the ack unless hold is set,
  // in which case mem_req stays high and the FSM sees it again after ACK.
  task automatic txn(input logic we, input logic [15:0] a, input logic [15:0] d,
                     input bit hold, output int lat);
    mem_req = 1; mem_we = we; mem_address = a; data_to_mem_store = d; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (rnd_io) io_in = 16'($urandom);
    end while (!mem_ack && lat < 10);
    if (!mem_ack) chk("ack_timeout", {15'b0, mem_ack}, 16'd1);
    if (!hold) begin
      mem_req = 0;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    logic [15:0] a;
    reset = 0; mem_req = 0; mem_we = 0; mem_address = 0;
    data_to_mem_store = 0; io_in = 16'h1234;
    repeat (2) @(negedge clk);
    en = 1;
    chk("rst_data", data_from_mem, 16'h0000);
    chk("rst_ack", {15'b0, mem_ack}, 16'd0);
    chk("rst_io_out", io_out, 16'h0000);
    chk("rst_bus_error", {15'b0, bus_error}, 16'd0);
    reset = 1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) txn(1, 16'(i), 16'($urandom), 0, lat);
    txn(1, 16'd1023, 16'($urandom), 0, lat);

    txn(1, 16'h0005, 16'hBEEF, 0, lat);
    chk("wr_ram_latency", 16'(lat), 16'd1);
    txn(0, 16'h0005, 16'h0000, 0, lat);
    chk("rd_ram_latency", 16'(lat), 16'd2);
    chk("rd_ram_data", data_from_mem, 16'hBEEF);
    chk("rd_ram_bus_error", {15'b0, bus_error}, 16'd0);

    txn(1, 16'hFF01, 16'h00A5, 0, lat);
    chk("io_out_written", io_out, 16'h00A5);
    txn(0, 16'hFF01, 16'h0000, 0, lat);
    chk("io_out_readback", data_from_mem, 16'h00A5);
    txn(0, 16'hFF00, 16'h0000, 0, lat);
    chk("io_in_read", data_from_mem, 16'h1234);
    txn(1, 16'hFF00, 16'h7777, 0, lat);
    chk("io_in_write_no_error", {15'b0, bus_error}, 16'd0);

    txn(1, 16'hFF02, 16'hFFFE, 0, lat);
    @(negedge clk);
    txn(0, 16'hFF02, 16'h0000, 0, lat);
    chk("timer_wrap_read", data_from_mem, 16'h0001);

    txn(0, 16'h8000, 16'h0000, 0, lat);
    chk("unmapped_latency", 16'(lat), 16'd2);
    chk("unmapped_data", data_from_mem, 16'h0000);
    chk("unmapped_bus_error", {15'b0, bus_error}, 16'd1);
    txn(0, 16'h0005, 16'h0000, 0, lat);
    chk("bus_error_sticky", {15'b0, bus_error}, 16'd1);
    chk("after_unmapped_data", data_from_mem, 16'hBEEF);

    txn(0, 16'h0000, 16'h0000, 1, lat);
    txn(0, 16'h0000, 16'h0000, 0, lat);
    chk("held_req_ack_spacing", 16'(lat), 16'd3);

    mem_req = 1; mem_we = 0; mem_address = 16'h0005;
    @(negedge clk);
    reset = 0; mem_req = 0;
    @(negedge clk);
    chk("midrst_ack", {15'b0, mem_ack}, 16'd0);
    chk("midrst_data", data_from_mem, 16'h0000);
    chk("midrst_io_out", io_out, 16'h0000);
    chk("midrst_bus_error", {15'b0, bus_error}, 16'd0);
    reset = 1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_late_ack", {15'b0, mem_ack}, 16'd0);
    end
    txn(0, 16'h0005, 16'h0000, 0, lat);
    chk("ram_survives_reset", data_from_mem, 16'hBEEF);

    rnd_io = 1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 16'($urandom_range(0, 15));
        4:          a = 16'd1023;
        5:          a = 16'd1024;
        6:          a = 16'hFF00;
        7:          a = 16'hFF01;
        8:          a = 16'hFF02;
        default: begin
          case ($urandom_range(0, 2))
            0:       a = 16'h8000;
            1:       a = 16'hFF03;
            default: a = 16'hFFFF;
          endcase
        end
      endcase
      txn(1'($urandom_range(0, 1)), a, 16'($urandom), ($urandom_range(0, 7) == 0), lat);
    end
    mem_req = 0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
